// File: rtl/vec_ctrl_pkg.sv
// Shared definitions for the vector beat sequencer: ALU op encodings,
// sequencer state encoding, default geometry and the decoded-control bundle.
package vec_ctrl_pkg;

  localparam int VLEN_DEF       = 16;
  localparam int LANES_DEF      = 4;
  localparam int MUL_CYCLES_DEF = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_ORR = 3'b011,
    ALU_MUL = 3'b100,
    ALU_AVG = 3'b101,
    ALU_THR = 3'b110,
    ALU_SHL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_WAIT_MUL = 2'b10,
    ST_HALTED   = 2'b11
  } seq_state_e;

  typedef struct packed {
    alu_op_e    alu;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic [2:0] rd;
  } beat_ctrl_t;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == ALU_MUL);
  endfunction

endpackage

// File: rtl/vec_beat_counter.sv
// Element-index register for the beat sequencer: clears on a new instruction,
// steps by LANES per consumed beat and flags the final beat of the vector.
module vec_beat_counter
  import vec_ctrl_pkg::*;
#(
  parameter int VLEN  = VLEN_DEF,
  parameter int LANES = LANES_DEF,
  parameter int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_zero,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - LANES);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             last_s;

  // final-beat compare on the registered index
  always_comb begin
    last_s = (idx_q == LAST_IDX);
  end

  // next index: a new instruction wins, and the index never steps past the last beat
  always_comb begin
    idx_d = idx_q;
    if (load_zero) begin
      idx_d = {IDX_W{1'b0}};
    end else if (advance && !last_s) begin
      idx_d = idx_q + STEP;
    end else begin
      idx_d = idx_q;
    end
  end

  // index register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= {IDX_W{1'b0}};
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign last = last_s;

endmodule

// File: rtl/vec_beat_sequencer.sv
// Sequences one decoded vector instruction over VLEN elements in LANES-wide
// beats, stretching MUL beats and freezing permanently on a halt instruction.
module vec_beat_sequencer
  import vec_ctrl_pkg::*;
#(
  parameter int VLEN       = VLEN_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int IDX_W      = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             halt_req,
  input  logic [2:0]       alu_ctrl,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             mem_to_reg,
  input  logic [2:0]       rd,
  output logic             beat_valid,
  output logic [IDX_W-1:0] beat_idx,
  output logic             beat_last,
  output logic [2:0]       beat_alu_ctrl,
  output logic             beat_reg_write,
  output logic             beat_mem_write,
  output logic             beat_mem_to_reg,
  output logic [2:0]       beat_rd,
  input  logic             beat_stall,
  output logic             stall_pipe,
  output logic             busy,
  output logic             halted
);

  if ((LANES < 1) || (LANES > VLEN) || ((VLEN % LANES) != 0) || (MUL_CYCLES < 1)) begin : g_bad_params
    $error("vec_beat_sequencer: illegal VLEN/LANES/MUL_CYCLES combination");
  end

  localparam int               CNT_W       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             MUL_WAIT_EN = (MUL_CYCLES > 1) ? 1'b1 : 1'b0;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  beat_ctrl_t       ctrl_q, ctrl_d;

  logic             issue_ready_s;
  logic             accept_s;
  logic             start_s;
  logic             advance_s;
  logic             launch_mul_s;
  seq_state_e       launch_state_s;
  logic [IDX_W-1:0] idx_s;
  logic             last_s;

  vec_beat_counter #(
    .VLEN  (VLEN),
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_zero (start_s),
    .advance   (advance_s),
    .idx       (idx_s),
    .last      (last_s)
  );

  // acceptance: idle, or the last beat leaving this cycle (zero-bubble handoff)
  always_comb begin
    issue_ready_s  = 1'b0;
    case (state_q)
      ST_IDLE: issue_ready_s = 1'b1;
      ST_RUN:  issue_ready_s = last_s & ~beat_stall;
      default: issue_ready_s = 1'b0;
    endcase
    accept_s       = issue_ready_s & issue_valid;
    start_s        = accept_s & ~halt_req;
    advance_s      = (state_q == ST_RUN) & ~beat_stall;
    launch_mul_s   = MUL_WAIT_EN & is_mul_op(alu_ctrl);
    launch_state_s = halt_req ? ST_HALTED : (launch_mul_s ? ST_WAIT_MUL : ST_RUN);
  end

  // next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = launch_state_s;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (beat_stall) begin
          state_d = ST_RUN;
        end else if (!last_s) begin
          if (MUL_WAIT_EN && is_mul_op(ctrl_q.alu)) begin
            state_d = ST_WAIT_MUL;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (accept_s) begin
          state_d = launch_state_s;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_MUL: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WAIT_MUL;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // latched decode controls for the instruction in flight
  always_comb begin
    ctrl_d = ctrl_q;
    if (start_s) begin
      ctrl_d.alu        = alu_op_e'(alu_ctrl);
      ctrl_d.reg_write  = reg_write;
      ctrl_d.mem_write  = mem_write;
      ctrl_d.mem_to_reg = mem_to_reg;
      ctrl_d.rd         = rd;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // state, wait counter and control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // outputs decoded from state; every output is held low while reset is asserted
  always_comb begin
    issue_ready     = 1'b0;
    stall_pipe      = 1'b0;
    busy            = 1'b0;
    halted          = 1'b0;
    beat_valid      = 1'b0;
    beat_idx        = {IDX_W{1'b0}};
    beat_last       = 1'b0;
    beat_alu_ctrl   = 3'b000;
    beat_reg_write  = 1'b0;
    beat_mem_write  = 1'b0;
    beat_mem_to_reg = 1'b0;
    beat_rd         = 3'b000;
    if (rst_n) begin
      issue_ready     = issue_ready_s;
      stall_pipe      = ~issue_ready_s;
      busy            = (state_q == ST_RUN) | (state_q == ST_WAIT_MUL);
      halted          = (state_q == ST_HALTED);
      beat_valid      = (state_q == ST_RUN);
      beat_idx        = idx_s;
      beat_last       = (state_q == ST_RUN) & last_s;
      beat_alu_ctrl   = ctrl_q.alu;
      beat_reg_write  = (state_q == ST_RUN) & ctrl_q.reg_write;
      beat_mem_write  = (state_q == ST_RUN) & ctrl_q.mem_write;
      beat_mem_to_reg = (state_q == ST_RUN) & ctrl_q.mem_to_reg;
      beat_rd         = ctrl_q.rd;
    end else begin
      beat_valid = 1'b0;
    end
  end

endmodule

// File: doc/vec_beat_sequencer.md
Name: vec_beat_sequencer

Overview:
- Sits between decode and the vector execute lanes.
- Accepts one decoded vector instruction at a time and sequences it over VLEN elements in beats of LANES elements.
- Drives the element index and per-beat control to the lanes, and stalls fetch/decode while the instruction is in flight.
- Inserts extra wait cycles per beat for multi-cycle MUL, and freezes the pipe permanently on a halt (Stuck) instruction.

Parameters:
- VLEN, 16, elements per vector register; must be a multiple of LANES.
- LANES, 4, elements processed per beat; 1 <= LANES <= VLEN.
- MUL_CYCLES, 3, cycles per MUL beat; must be >= 1.
- IDX_W, $clog2(VLEN), element index width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  sequencer accepts the instruction this cycle.
- halt_req  in  1  presented instruction is Stuck/halt.
- alu_ctrl  in  3  ALU op (000 ADD ... 100 MUL ... 111 SHL).
- reg_write, mem_write, mem_to_reg  in  1 each  decoded controls.
- rd  in  3  destination vector register.
- beat_valid  out  1  current beat is presented to the lanes.
- beat_idx  out  IDX_W  base element index of the beat.
- beat_last  out  1  current beat is the final beat.
- beat_alu_ctrl  out  3  latched op.
- beat_reg_write, beat_mem_write, beat_mem_to_reg  out  1 each  latched controls, gated by beat_valid.
- beat_rd  out  3  latched destination.
- beat_stall  in  1  downstream/memory cannot take the beat.
- stall_pipe  out  1  stall fetch/decode; equals ~issue_ready.
- busy  out  1  state is RUN or WAIT_MUL.
- halted  out  1  halt state reached.

Behaviour:
- States: IDLE, RUN, WAIT_MUL, HALTED.
- Reset (rst_n=0 at an edge, any state, including mid-instruction):
  - next state IDLE; all latched fields, beat_idx and wait counter cleared to 0.
  - While rst_n=0, all outputs are forced to 0, including issue_ready.
- IDLE:
  - issue_ready=1, beat_valid=0.
  - On issue_valid & halt_req: go to HALTED; no beat is issued.
  - On issue_valid & ~halt_req: latch the controls and rd, set beat_idx=0.
  - Next state is WAIT_MUL with cnt=MUL_CYCLES-1 if alu_ctrl==MUL and MUL_CYCLES>1; otherwise RUN.
- WAIT_MUL:
  - beat_valid=0, beat_idx stable.
  - cnt decrements each cycle; when cnt==1, next state is RUN.
  - beat_stall is ignored in this state.
- RUN:
  - beat_valid=1; beat_last = (beat_idx == VLEN-LANES).
  - beat_stall=1: hold all outputs and state.
  - beat_stall=0 and not last: beat_idx += LANES; re-enter WAIT_MUL (cnt reloaded) if MUL, else stay in RUN.
  - beat_stall=0 and last: the instruction completes; issue_ready=1 in this same cycle (zero-bubble back-to-back).
  - On completion, a concurrent issue is handled exactly as in IDLE; with no issue, go to IDLE.
- HALTED:
  - halted=1, issue_ready=0, stall_pipe=1.
  - issue_valid is ignored; only reset exits.
- issue_ready is combinational from state, beat_last and beat_stall. No other combinational input-to-output paths.
- beat_idx never wraps past VLEN-LANES.
- Latency:
  - Non-MUL: first beat 1 cycle after accept; VLEN/LANES cycles total with no stall.
  - MUL: first beat MUL_CYCLES cycles after accept; VLEN/LANES*MUL_CYCLES cycles total.
- Elaboration: illegal parameter values (VLEN % LANES != 0, LANES > VLEN, MUL_CYCLES < 1) cause an elaboration-time $error.

Decomposition:
- Shared package vec_ctrl_pkg holds:
  - the ALU op encodings (ADD, SUB, AND, ORR, MUL, AVG, THR, SHL);
  - the state enum;
  - the VLEN/LANES defaults.
- One sub-module, vec_beat_counter (beat_idx register, increment by LANES, beat_last compare, load-zero). The FSM and wait counter stay in the top.

Test Plan (VLEN=16, LANES=4, MUL_CYCLES=3):
1. rst_n=0 for 2 cycles, then 1 -> all outputs 0 during reset; issue_ready=1 and stall_pipe=0 in the first cycle after release.
2. ADD issued cycle 0, no stall -> beat_valid cycles 1-4 with beat_idx 0,4,8,12; beat_last only at cycle 4; issue_ready=1 at cycle 4.
3. ADD at cycle 0, then SUB held valid -> SUB accepted at cycle 4; SUB beats at cycles 5-8 with beat_alu_ctrl=001, beat_idx 0..12.
4. MUL issued cycle 0 -> beat_valid only at cycles 3,6,9,12 (idx 0,4,8,12); busy=1 cycles 1-12; stall_pipe=1 cycles 1-11.
5. ADD at cycle 0, beat_stall=1 cycles 2-3 -> beat_idx=4 held cycles 2-4; idx 8 at cycle 5, idx 12 at cycle 6; no beat dropped or duplicated.
6. Halt issued cycle 0 -> halted=1 from cycle 1 onward, and issue_ready stays 0 despite issue_valid; rst_n=0 at cycle 5 -> IDLE at cycle 6 with halted=0. Separately, rst_n=0 mid-MUL (cycle 4) -> beat_valid=0 and beat_idx=0 next cycle.
